// File: rtl/tamagotchi_scheduler.sv
// Stat-update command sequencer for the tamagotchi datapath.
// Care button edges and per-stat decay timers become one arbitrated valid/ready command stream.
module tamagotchi_scheduler #(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned DECAY_SALUD     = 120,
    parameter int unsigned DECAY_ENERGIA   = 100,
    parameter int unsigned DECAY_HAMBRE    = 70,
    parameter int unsigned DECAY_DIVERSION = 50
) (
    input  logic       clk,
    input  logic       btn_reset,
    input  logic       btn_salud,
    input  logic       btn_energia,
    input  logic       btn_hambre,
    input  logic       btn_diversion,
    input  logic       btn_test,
    input  logic       ledsign,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_stat,
    output logic [1:0] cmd_op,
    output logic       test_mode,
    output logic [1:0] sel_stat,
    output logic       tick
);

    localparam int unsigned PW       = $clog2(TICK_DIV);
    localparam int unsigned MaxSE    = (DECAY_SALUD > DECAY_ENERGIA) ? DECAY_SALUD : DECAY_ENERGIA;
    localparam int unsigned MaxHD    = (DECAY_HAMBRE > DECAY_DIVERSION) ? DECAY_HAMBRE
                                                                       : DECAY_DIVERSION;
    localparam int unsigned DecayMax = (MaxSE > MaxHD) ? MaxSE : MaxHD;
    localparam int unsigned DW       = $clog2(DecayMax + 1);

    localparam logic [1:0] StatEnergia = 2'd1;

    typedef enum logic [1:0] {
        OpInc    = 2'd0,
        OpDec    = 2'd1,
        OpSetMin = 2'd2,
        OpSetMax = 2'd3
    } op_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StOut  = 1'b1
    } state_e;

    function automatic logic [DW-1:0] decay_last(input int unsigned s);
        case (s)
            0:       decay_last = DW'(DECAY_SALUD - 1);
            1:       decay_last = DW'(DECAY_ENERGIA - 1);
            2:       decay_last = DW'(DECAY_HAMBRE - 1);
            default: decay_last = DW'(DECAY_DIVERSION - 1);
        endcase
    endfunction

    state_e             state_q, state_d;
    logic [1:0]         cmd_stat_q, cmd_stat_d;
    op_e                cmd_op_q, cmd_op_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         sel_stat_q, sel_stat_d;
    logic [4:0]         btn_q, btn_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [3:0][DW-1:0] dcnt_q, dcnt_d;
    logic [3:0]         care_pend_q, care_pend_d;
    logic [3:0]         decay_pend_q, decay_pend_d;
    logic [3:0]         tog_q, tog_d;
    logic               test_mode_q, test_mode_d;

    logic [4:0] btn_rise;
    logic [3:0] care_evt, dec_fire, cand, grant_oh;
    logic       test_evt, freeze, tick_int, care_cls, load, grant_valid;
    logic [1:0] grant_stat, rr_idx;
    op_e        grant_op;

    // Bit order: salud, energia, hambre, diversion, test.
    assign btn_d = {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud};

    always_comb begin
        btn_rise = btn_d & ~btn_q;
        care_evt = btn_rise[3:0];
        if (!ledsign) begin
            care_evt[StatEnergia] = 1'b0;
        end
        test_evt = btn_rise[4] & ~test_mode_q;
        freeze   = test_mode_q | test_evt;
    end

    assign tick_int = ~test_mode_q & (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d  = presc_q;
        dcnt_d   = dcnt_q;
        dec_fire = '0;
        if (!freeze) begin
            presc_d = tick_int ? '0 : presc_q + 1'b1;
        end
        if (tick_int && !test_evt) begin
            for (int unsigned s = 0; s < 4; s++) begin
                // Energia recovers only while the pet sleeps; otherwise its timer holds.
                if (s != 1 || !ledsign) begin
                    if (dcnt_q[s] == decay_last(s)) begin
                        dcnt_d[s]   = '0;
                        dec_fire[s] = 1'b1;
                    end else begin
                        dcnt_d[s] = dcnt_q[s] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        care_cls    = |care_pend_q;
        cand        = care_cls ? care_pend_q : (test_evt ? 4'b0000 : decay_pend_q);
        grant_valid = |cand;
        grant_stat  = '0;
        rr_idx      = '0;
        // Walk from the farthest slot back to the pointer so the nearest request wins.
        for (int i = 3; i >= 0; i--) begin
            rr_idx = rr_ptr_q + 2'(i);
            if (cand[rr_idx]) begin
                grant_stat = rr_idx;
            end
        end
        grant_op = OpInc;
        if (care_cls) begin
            if (test_mode_q) begin
                grant_op = tog_q[grant_stat] ? OpSetMax : OpSetMin;
            end else begin
                grant_op = (grant_stat == StatEnergia) ? OpDec : OpInc;
            end
        end else begin
            grant_op = (grant_stat == StatEnergia) ? OpInc : OpDec;
        end
        load     = (state_q == StIdle) | cmd_ready;
        grant_oh = (load && grant_valid) ? (4'b0001 << grant_stat) : 4'b0000;
    end

    always_comb begin
        // New requests are OR-ed in after the grant clear, so a same-cycle request survives.
        care_pend_d  = (care_pend_q & ~(care_cls ? grant_oh : 4'b0000)) | care_evt;
        decay_pend_d = freeze ? 4'b0000
                              : (decay_pend_q & ~(care_cls ? 4'b0000 : grant_oh)) | dec_fire;
        tog_d = tog_q;
        if (test_evt) begin
            tog_d = '0;
        end else if (test_mode_q && care_cls) begin
            tog_d = tog_q ^ grant_oh;
        end
        test_mode_d = test_mode_q | test_evt;
        sel_stat_d  = sel_stat_q;
        for (int s = 3; s >= 0; s--) begin
            if (care_evt[s]) begin
                sel_stat_d = 2'(s);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_stat_d = cmd_stat_q;
        cmd_op_d   = cmd_op_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            StIdle:  if (grant_valid) state_d = StOut;
            StOut:   if (cmd_ready && !grant_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (load && grant_valid) begin
            cmd_stat_d = grant_stat;
            cmd_op_d   = grant_op;
            rr_ptr_d   = grant_stat + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge btn_reset) begin
        if (!btn_reset) begin
            state_q      <= StIdle;
            cmd_stat_q   <= '0;
            cmd_op_q     <= OpInc;
            rr_ptr_q     <= '0;
            sel_stat_q   <= '0;
            btn_q        <= '0;
            presc_q      <= '0;
            dcnt_q       <= '0;
            care_pend_q  <= '0;
            decay_pend_q <= '0;
            tog_q        <= '0;
            test_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_stat_q   <= cmd_stat_d;
            cmd_op_q     <= cmd_op_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_stat_q   <= sel_stat_d;
            btn_q        <= btn_d;
            presc_q      <= presc_d;
            dcnt_q       <= dcnt_d;
            care_pend_q  <= care_pend_d;
            decay_pend_q <= decay_pend_d;
            tog_q        <= tog_d;
            test_mode_q  <= test_mode_d;
        end
    end

    assign cmd_valid = (state_q == StOut);
    assign cmd_stat  = cmd_stat_q;
    assign cmd_op    = cmd_op_q;
    assign test_mode = test_mode_q;
    assign sel_stat  = sel_stat_q;
    assign tick      = tick_int;

endmodule

// File: tb/tb_tamagotchi_scheduler.sv
// Bench for tamagotchi_scheduler: directed scenarios plus random traffic, all checked per cycle
// against a behavioural model of pending requests, timers and the command slot.
module tb_tamagotchi_scheduler;

    localparam int unsigned TD = 4;
    localparam int unsigned DS = 40;
    localparam int unsigned DE = 1;
    localparam int unsigned DH = 30;
    localparam int unsigned DD = 2;

    logic       clk = 1'b0;
    logic       btn_reset = 1'b0;
    logic       btn_salud = 1'b0, btn_energia = 1'b0, btn_hambre = 1'b0, btn_diversion = 1'b0;
    logic       btn_test = 1'b0;
    logic       ledsign = 1'b1;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid, test_mode, tick;
    logic [1:0] cmd_stat, cmd_op, sel_stat;

    int n_cmp  = 0;
    int n_fail = 0;

    tamagotchi_scheduler #(
        .TICK_DIV       (TD),
        .DECAY_SALUD    (DS),
        .DECAY_ENERGIA  (DE),
        .DECAY_HAMBRE   (DH),
        .DECAY_DIVERSION(DD)
    ) dut (
        .clk          (clk),
        .btn_reset    (btn_reset),
        .btn_salud    (btn_salud),
        .btn_energia  (btn_energia),
        .btn_hambre   (btn_hambre),
        .btn_diversion(btn_diversion),
        .btn_test     (btn_test),
        .ledsign      (ledsign),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_stat     (cmd_stat),
        .cmd_op       (cmd_op),
        .test_mode    (test_mode),
        .sel_stat     (sel_stat),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int       m_presc;
    int       m_cnt[4];
    bit [3:0] m_care, m_dec, m_tog;
    bit [4:0] m_prev;
    bit       m_tm, m_valid;
    int       m_ptr, m_sel, m_stat, m_op;

    function automatic int lim(input int s);
        case (s)
            0:       return DS;
            1:       return DE;
            2:       return DH;
            default: return DD;
        endcase
    endfunction

    task automatic model_reset();
        m_presc = 0;
        for (int s = 0; s < 4; s++) m_cnt[s] = 0;
        m_care = '0; m_dec = '0; m_tog = '0; m_prev = '0;
        m_tm = 0; m_valid = 0; m_ptr = 0; m_sel = 0; m_stat = 0; m_op = 0;
    endtask

    task automatic model_step();
        bit [4:0] b;
        bit [3:0] ev, cand, fire;
        bit       tick_now, tevt, load, care_cls, got;
        int       g;
        b        = {btn_test, btn_diversion, btn_hambre, btn_energia, btn_salud};
        tick_now = !m_tm && (m_presc == TD - 1);
        ev       = b[3:0] & ~m_prev[3:0];
        if (!ledsign) ev[1] = 1'b0;
        tevt     = b[4] && !m_prev[4] && !m_tm;
        load     = !m_valid || cmd_ready;
        care_cls = (m_care != 0);
        cand     = care_cls ? m_care : (tevt ? 4'b0 : m_dec);
        got = 0;
        g   = 0;
        if (load) begin
            for (int k = 0; k < 4; k++) begin
                int s;
                s = (m_ptr + k) % 4;
                if (!got && cand[s]) begin
                    got = 1;
                    g   = s;
                end
            end
            m_valid = got;
        end
        if (got) begin
            if (care_cls) begin
                if (m_tm) m_op = m_tog[g] ? 3 : 2;
                else      m_op = (g == 1) ? 1 : 0;
                if (m_tm) m_tog[g] = !m_tog[g];
                m_care[g] = 0;
            end else begin
                m_op     = (g == 1) ? 0 : 1;
                m_dec[g] = 0;
            end
            m_stat = g;
            m_ptr  = (g + 1) % 4;
        end
        m_care = m_care | ev;
        fire   = '0;
        if (tick_now && !tevt) begin
            for (int s = 0; s < 4; s++) begin
                if (s != 1 || !ledsign) begin
                    if (m_cnt[s] == lim(s) - 1) begin
                        m_cnt[s] = 0;
                        fire[s]  = 1;
                    end else begin
                        m_cnt[s]++;
                    end
                end
            end
        end
        m_dec = m_dec | fire;
        if (m_tm || tevt) m_dec = '0;
        else m_presc = (m_presc + 1) % TD;
        if (tevt) begin
            m_tm  = 1;
            m_tog = '0;
        end
        for (int s = 3; s >= 0; s--) if (ev[s]) m_sel = s;
        m_prev = b;
    endtask

    function automatic logic [8:0] dut_vec();
        return {cmd_valid, cmd_valid ? cmd_stat : 2'b00, cmd_valid ? cmd_op : 2'b00,
                tick, test_mode, sel_stat};
    endfunction

    function automatic logic [8:0] model_vec();
        logic t;
        t = !m_tm && (m_presc == TD - 1);
        return {m_valid, m_valid ? 2'(m_stat) : 2'b00, m_valid ? 2'(m_op) : 2'b00,
                t, m_tm, 2'(m_sel)};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic apply_reset();
        btn_reset = 1'b0;
        btn_salud = 0; btn_energia = 0; btn_hambre = 0; btn_diversion = 0; btn_test = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 btn_reset = 1'b1;
    endtask

    task automatic test_reset();
        btn_reset = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec() !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_async: got %b want %b", dut_vec(), 9'b0);
        end
        btn_salud = 1; btn_hambre = 1; cmd_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_held: got %b want %b", dut_vec(), 9'b0);
        end
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL reset_after cyc %0d: got %b want %b", i, dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_decay_tick();
        int ticks, cmds, bad;
        apply_reset();
        ledsign = 1; cmd_ready = 1;
        ticks = 0; cmds = 0; bad = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL decay_model cyc %0d: got %b want %b", i, dut_vec(), model_vec());
            end
            if (tick) ticks++;
            if (tick !== (i % 4 == 3)) bad++;
            if (cmd_valid) begin
                cmds++;
                if (cmd_stat !== 2'd3 || cmd_op !== 2'd1 || (i != 9 && i != 17)) bad++;
            end
        end
        n_cmp++;
        if (ticks != 6 || cmds != 2 || bad != 0) begin
            n_fail++;
            $display("FAIL decay_tick: got ticks=%0d cmds=%0d bad=%0d want 6 2 0",
                     ticks, cmds, bad);
        end
    endtask

    task automatic test_care_pair();
        int bad;
        apply_reset();
        ledsign = 1; cmd_ready = 0; btn_salud = 1; btn_hambre = 1;
        bad = 0;
        for (int i = 1; i <= 7; i++) begin
            if (i == 7) cmd_ready = 1;
            step();
            btn_salud = 0; btn_hambre = 0;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL care_pair_model cyc %0d: got %b want %b", i, dut_vec(), model_vec());
            end
            if (i >= 2 && i <= 6 && {cmd_valid, cmd_stat, cmd_op} !== 5'b1_00_00) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL care_pair_hold: got %0d unstable cycles want 0", bad);
        end
        n_cmp++;
        if ({cmd_valid, cmd_stat, cmd_op, sel_stat} !== 7'b1_10_00_00) begin
            n_fail++;
            $display("FAIL care_pair_next: got v=%b s=%0d op=%0d sel=%0d want v=1 s=2 op=0 sel=0",
                     cmd_valid, cmd_stat, cmd_op, sel_stat);
        end
    endtask

    task automatic test_energia_sleep();
        int inc_cnt, dec_cnt, bad_sel, late;
        apply_reset();
        ledsign = 0; cmd_ready = 1;
        inc_cnt = 0; dec_cnt = 0; bad_sel = 0; late = 0;
        for (int i = 1; i <= 36; i++) begin
            btn_energia = (i == 2);
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL energia_model cyc %0d: got %b want %b", i, dut_vec(), model_vec());
            end
            if (sel_stat !== 2'd0) bad_sel++;
            if (cmd_valid && cmd_stat == 2'd1) begin
                if (cmd_op == 2'd1) dec_cnt++;
                if (i <= 16 && cmd_op == 2'd0) inc_cnt++;
                if (i >= 21) late++;
            end
            if (i == 16) ledsign = 1;
        end
        n_cmp++;
        if (inc_cnt != 3 || dec_cnt != 0 || bad_sel != 0 || late != 0) begin
            n_fail++;
            $display("FAIL energia_sleep: got inc=%0d dec=%0d badsel=%0d late=%0d want 3 0 0 0",
                     inc_cnt, dec_cnt, bad_sel, late);
        end
    endtask

    task automatic test_care_over_decay();
        logic [4:0] seen[4];
        logic [4:0] want[4];
        apply_reset();
        ledsign = 1; cmd_ready = 0;
        want[0] = 5'b1_00_00; want[1] = 5'b1_11_00; want[2] = 5'b1_11_01; want[3] = 5'b0_00_00;
        for (int i = 1; i <= 22; i++) begin
            btn_salud     = (i == 17);
            btn_diversion = (i == 17);
            if (i == 19) cmd_ready = 1;
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL order_model cyc %0d: got %b want %b", i, dut_vec(), model_vec());
            end
            if (i >= 19) seen[i-19] = {cmd_valid, cmd_valid ? cmd_stat : 2'b0,
                                      cmd_valid ? cmd_op : 2'b0};
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (seen[k] !== want[k]) begin
                n_fail++;
                $display("FAIL order slot %0d: got %b want %b", k, seen[k], want[k]);
            end
        end
    endtask

    task automatic test_test_mode();
        int ticks, cmds, bad;
        logic [1:0] ops[4];
        apply_reset();
        ledsign = 1; cmd_ready = 1;
        ops[0] = 2'd2; ops[1] = 2'd3; ops[2] = 2'd2; ops[3] = 2'd3;
        ticks = 0; cmds = 0; bad = 0;
        for (int i = 1; i <= 1000; i++) begin
            btn_test   = (i == 1 || i == 12);
            btn_hambre = (i == 3 || i == 6 || i == 9 || i == 14);
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL test_mode_model cyc %0d: got %b want %b", i, dut_vec(),
                         model_vec());
            end
            if (tick) ticks++;
            if (test_mode !== 1'b1) bad++;
            if (cmd_valid) begin
                if (cmds >= 4 || cmd_stat !== 2'd2 || cmd_op !== ops[cmds]) bad++;
                cmds++;
            end
        end
        n_cmp++;
        if (ticks != 0 || cmds != 4 || bad != 0) begin
            n_fail++;
            $display("FAIL test_mode: got ticks=%0d cmds=%0d bad=%0d want 0 4 0", ticks, cmds, bad);
        end
    endtask

    task automatic test_hold_reset();
        int acc;
        apply_reset();
        ledsign = 1; cmd_ready = 0; btn_salud = 1; btn_test = 1;
        acc = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 2) btn_test = 0;
            if (i == 11) cmd_ready = 1;
            if (cmd_valid && cmd_ready && cmd_stat == 2'd0) acc++;
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL hold_model cyc %0d: got %b want %b", i, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (acc != 1) begin
            n_fail++;
            $display("FAIL hold_once: got %0d salud accepts want 1", acc);
        end
        cmd_ready = 0; btn_hambre = 1;
        step();
        btn_hambre = 0;
        step();
        n_cmp++;
        if (cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_inflight: got cmd_valid=%b want 1", cmd_valid);
        end
        btn_reset = 1'b0;
        #1;
        n_cmp++;
        if (cmd_valid !== 1'b0 || test_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_async_reset: got v=%b tm=%b want 0 0", cmd_valid, test_mode);
        end
        apply_reset();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 750 == 749) apply_reset();
            btn_salud     = ($urandom_range(0, 3) == 0);
            btn_energia   = ($urandom_range(0, 3) == 0);
            btn_hambre    = ($urandom_range(0, 3) == 0);
            btn_diversion = ($urandom_range(0, 3) == 0);
            btn_test      = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 39) == 0) ledsign = !ledsign;
            cmd_ready = ($urandom_range(0, 9) < 7);
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", c, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_decay_tick();
        test_care_pair();
        test_energia_sleep();
        test_care_over_decay();
        test_test_mode();
        test_hold_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
